// File: rtl/ila_pkg.sv
// Shared definitions for the ILA capture core: control-bus bit map, host
// opcodes, trigger-configuration field codes and the capture FSM states.
package ila_pkg;

  localparam int CMD_VALID_BIT  = 0;
  localparam int OPCODE_LSB     = 1;
  localparam int OPCODE_MSB     = 3;
  localparam int ARG_LSB        = 4;
  localparam int ARG_MSB        = 15;

  localparam int RESP_VALID_BIT = 16;
  localparam int ARMED_BIT      = 17;
  localparam int TRIGGERED_BIT  = 18;
  localparam int DONE_BIT       = 19;
  localparam int RESP_DATA_LSB  = 20;
  localparam int RESP_DATA_MSB  = 35;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_ARM       = 3'd1,
    OP_ABORT     = 3'd2,
    OP_SET_TRIG  = 3'd3,
    OP_SET_RADDR = 3'd4,
    OP_READ      = 3'd5,
    OP_STATUS    = 3'd6,
    OP_RSVD      = 3'd7
  } opcode_e;

  localparam logic [3:0] FLD_SEL     = 4'd0;
  localparam logic [3:0] FLD_VAL_LO  = 4'd1;
  localparam logic [3:0] FLD_VAL_HI  = 4'd2;
  localparam logic [3:0] FLD_MASK_LO = 4'd3;
  localparam logic [3:0] FLD_MASK_HI = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Status response layout: flags on top, trigger index in the low 10 bits.
  function automatic logic [15:0] make_status(input logic done, input logic triggered,
                                              input logic armed, input logic [9:0] trig_idx);
    return {done, triggered, armed, 3'b000, trig_idx};
  endfunction

endpackage

// File: rtl/ila_sample_ram.sv
// Simple dual-port sample memory: synchronous write, registered read.
module ila_sample_ram
  import ila_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ila_capture_core.sv
// Single-probe logic analyzer: circular capture around a masked-compare
// trigger, with command/response access over a 36-bit debug bus.
module ila_capture_core
  import ila_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [DATA_W-1:0] trig0,
  inout  wire  [35:0]       control
);

  localparam int SLICES = DATA_W / 16;

  logic        cmd_valid;
  opcode_e     opcode;
  logic [11:0] arg;

  logic do_arm, do_abort, do_set_trig, do_set_raddr, do_read, do_status;
  logic arm_accept;

  logic [3:0]  trig_sel;
  logic [15:0] trig_value;
  logic [15:0] trig_mask;
  logic [15:0] trig_slice;
  logic        trig_hit;

  state_e state, state_n;
  logic   ram_we, trig_event, done_event;
  logic   armed, triggered, done;

  logic [ADDR_W-1:0] wr_ptr, trig_ptr, start_ptr, cnt, post_n, rd_idx, rd_addr, idx_diff;
  logic [9:0]        trig_idx;
  logic [15:0]       status_word;

  logic [DATA_W-1:0] ram_q;
  logic              rsp1_valid, rsp1_status;
  logic [3:0]        rsp1_chunk;
  logic [15:0]       rsp1_word;
  logic [15:0]       chunk_data;
  logic              resp_valid;
  logic [15:0]       resp_data;

  assign cmd_valid = control[CMD_VALID_BIT];
  assign opcode    = opcode_e'(control[OPCODE_MSB:OPCODE_LSB]);
  assign arg       = control[ARG_MSB:ARG_LSB];

  assign do_arm       = cmd_valid && (opcode == OP_ARM);
  assign do_abort     = cmd_valid && (opcode == OP_ABORT);
  assign do_set_trig  = cmd_valid && (opcode == OP_SET_TRIG);
  assign do_set_raddr = cmd_valid && (opcode == OP_SET_RADDR);
  assign do_read      = cmd_valid && (opcode == OP_READ);
  assign do_status    = cmd_valid && (opcode == OP_STATUS);

  assign arm_accept = do_arm && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      trig_sel   <= '0;
      trig_value <= '0;
      trig_mask  <= '0;
    end else if (do_set_trig) begin
      case (arg[11:8])
        FLD_SEL:     trig_sel         <= arg[3:0];
        FLD_VAL_LO:  trig_value[7:0]  <= arg[7:0];
        FLD_VAL_HI:  trig_value[15:8] <= arg[7:0];
        FLD_MASK_LO: trig_mask[7:0]   <= arg[7:0];
        FLD_MASK_HI: trig_mask[15:8]  <= arg[7:0];
        default: ;
      endcase
    end
  end

  // Slice selects beyond the probe width wrap around the available slices.
  always_comb begin
    trig_slice = '0;
    for (int i = 0; i < SLICES; i++) begin
      if ((int'(trig_sel) % SLICES) == i) begin
        trig_slice = trig0[16*i +: 16];
      end
    end
  end

  assign trig_hit = ((trig_slice & trig_mask) == (trig_value & trig_mask));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Abort overrides everything, including a trigger hit in the same cycle.
  always_comb begin
    state_n    = state;
    ram_we     = 1'b0;
    trig_event = 1'b0;
    done_event = 1'b0;
    armed      = 1'b0;
    triggered  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arm_accept) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        armed  = 1'b1;
        ram_we = 1'b1;
        if (trig_hit) begin
          state_n    = ST_POST;
          trig_event = 1'b1;
        end
      end
      ST_POST: begin
        armed     = 1'b1;
        triggered = 1'b1;
        if (cnt == '0) begin
          state_n    = ST_DONE;
          done_event = 1'b1;
        end else begin
          ram_we = 1'b1;
        end
      end
      ST_DONE: begin
        triggered = 1'b1;
        done      = 1'b1;
        if (arm_accept) state_n = ST_ARMED;
      end
      default: state_n = ST_IDLE;
    endcase
    if (do_abort) begin
      state_n    = ST_IDLE;
      ram_we     = 1'b0;
      trig_event = 1'b0;
      done_event = 1'b0;
    end
  end

  // Once the post-trigger count is exhausted, wr_ptr points at the oldest sample.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      start_ptr <= '0;
      cnt       <= '0;
      post_n    <= '0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (arm_accept) post_n <= arg[ADDR_W-1:0];
      if (trig_event) begin
        trig_ptr <= wr_ptr;
        cnt      <= post_n;
      end else if ((state == ST_POST) && ram_we) begin
        cnt <= cnt - ADDR_W'(1);
      end
      if (done_event) start_ptr <= wr_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_idx <= '0;
    end else if (do_set_raddr) begin
      rd_idx <= arg[ADDR_W-1:0];
    end else if (do_read && (int'(arg[3:0]) == SLICES - 1)) begin
      rd_idx <= rd_idx + ADDR_W'(1);
    end
  end

  assign rd_addr     = start_ptr + rd_idx;
  assign idx_diff    = trig_ptr - start_ptr;
  assign trig_idx    = 10'(idx_diff);
  assign status_word = make_status(done, triggered, armed, trig_idx);

  ila_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (trig0),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_comb begin
    chunk_data = '0;
    for (int i = 0; i < SLICES; i++) begin
      if (int'(rsp1_chunk) == i) begin
        chunk_data = ram_q[16*i +: 16];
      end
    end
  end

  // Stage 1 lines up with the RAM read register; stage 2 drives the bus.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rsp1_valid  <= 1'b0;
      rsp1_status <= 1'b0;
      rsp1_chunk  <= '0;
      rsp1_word   <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
    end else begin
      rsp1_valid  <= do_read || do_status;
      rsp1_status <= do_status;
      rsp1_chunk  <= arg[3:0];
      rsp1_word   <= status_word;
      resp_valid  <= rsp1_valid;
      if (rsp1_valid) begin
        resp_data <= rsp1_status ? rsp1_word : chunk_data;
      end
    end
  end

  assign control[RESP_VALID_BIT]              = resp_valid;
  assign control[ARMED_BIT]                   = armed;
  assign control[TRIGGERED_BIT]               = triggered;
  assign control[DONE_BIT]                    = done;
  assign control[RESP_DATA_MSB:RESP_DATA_LSB] = resp_data;

endmodule

// File: tb/tb_ila_capture_core.sv
// Directed self-checking bench for ila_capture_core: trigger, post count,
// readback, status, abort, ignored re-arm and asynchronous reset.
module tb_ila_capture_core;

  localparam logic [2:0] OP_ARM = 3'd1, OP_ABORT = 3'd2, OP_SET_TRIG = 3'd3;
  localparam logic [2:0] OP_SET_RADDR = 3'd4, OP_READ = 3'd5, OP_STATUS = 3'd6;

  logic         clk;
  logic         rst_b;
  logic [255:0] trig0;
  logic [15:0]  host;
  wire  [35:0]  control;

  int checks = 0;
  int errors = 0;

  assign control[15:0] = host;

  wire        resp_valid = control[16];
  wire        armed_o    = control[17];
  wire        trig_o     = control[18];
  wire        done_o     = control[19];
  wire [15:0] resp_data  = control[35:20];

  ila_capture_core #(.DATA_W(256), .ADDR_W(10)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .trig0   (trig0),
    .control (control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Strobe one command for a single cycle; returns at the following negedge.
  task automatic send_cmd(input logic [2:0] op, input logic [11:0] a);
    host = {a, op, 1'b1};
    @(negedge clk);
    host = '0;
  endtask

  function automatic logic [255:0] word_of(input int k);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = {4'(i), 12'(k)};
    return w;
  endfunction

  task automatic test_reset;
    checks++;
    if (control[35:16] !== 20'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 00000", control[35:16]);
    end
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    send_cmd(OP_STATUS, 12'h0);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status_early: got %b expected 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_status: got v=%b d=%h expected v=1 d=0000", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status_pulse: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_trigger_beef;
    send_cmd(OP_SET_TRIG, {4'd0, 8'h02});
    send_cmd(OP_SET_TRIG, {4'd1, 8'hEF});
    send_cmd(OP_SET_TRIG, {4'd2, 8'hBE});
    send_cmd(OP_SET_TRIG, {4'd3, 8'hFF});
    send_cmd(OP_SET_TRIG, {4'd4, 8'hFF});
    trig0 = '0;
    send_cmd(OP_ARM, 12'd4);
    checks++;
    if (armed_o !== 1'b1 || trig_o !== 1'b0) begin
      errors++; $display("[TB] FAIL beef_armed: got a=%b t=%b expected a=1 t=0", armed_o, trig_o);
    end
    for (int k = 0; k < 1000; k++) begin
      trig0 = '0;
      @(negedge clk);
    end
    checks++;
    if (trig_o !== 1'b0) begin
      errors++; $display("[TB] FAIL beef_no_early_trig: got %b expected 0", trig_o);
    end
    trig0[47:32] = 16'hBEEF;
    @(negedge clk);
    trig0 = '0;
    checks++;
    if (trig_o !== 1'b1 || armed_o !== 1'b1) begin
      errors++; $display("[TB] FAIL beef_triggered: got t=%b a=%b expected t=1 a=1", trig_o, armed_o);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0) begin
        errors++; $display("[TB] FAIL beef_done_early: got %b expected 0 at cycle %0d", done_o, i);
      end
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || armed_o !== 1'b0 || trig_o !== 1'b1) begin
      errors++; $display("[TB] FAIL beef_done: got d=%b a=%b t=%b expected d=1 a=0 t=1", done_o, armed_o, trig_o);
    end
    send_cmd(OP_STATUS, 12'h0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'hC3FB) begin
      errors++; $display("[TB] FAIL beef_status: got v=%b d=%h expected v=1 d=c3fb", resp_valid, resp_data);
    end
  endtask

  task automatic test_zero_mask;
    send_cmd(OP_SET_TRIG, {4'd3, 8'h00});
    send_cmd(OP_SET_TRIG, {4'd4, 8'h00});
    trig0 = '0;
    send_cmd(OP_ARM, 12'd0);
    checks++;
    if (armed_o !== 1'b1 || trig_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL zm_armed: got a=%b t=%b d=%b expected 1 0 0", armed_o, trig_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (trig_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL zm_trig: got t=%b d=%b expected t=1 d=0", trig_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("[TB] FAIL zm_done: got %b expected 1", done_o);
    end
    send_cmd(OP_STATUS, 12'h0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'hC3FF) begin
      errors++; $display("[TB] FAIL zm_status: got v=%b d=%h expected v=1 d=c3ff", resp_valid, resp_data);
    end
  endtask

  task automatic test_readback;
    int  k;
    bit  seen;
    send_cmd(OP_SET_TRIG, {4'd0, 8'h00});
    send_cmd(OP_SET_TRIG, {4'd1, 8'h4C});
    send_cmd(OP_SET_TRIG, {4'd2, 8'h04});
    send_cmd(OP_SET_TRIG, {4'd3, 8'hFF});
    send_cmd(OP_SET_TRIG, {4'd4, 8'h0F});
    trig0 = word_of(0);
    send_cmd(OP_ARM, 12'd20);
    k = 0; seen = 0;
    while (!seen && k < 1300) begin
      trig0 = word_of(k);
      @(negedge clk);
      if (done_o === 1'b1) seen = 1; else k++;
    end
    checks++;
    if (!seen || k != 1121) begin
      errors++; $display("[TB] FAIL rb_done_cycle: got seen=%0d k=%0d expected seen=1 k=1121", seen, k);
    end
    send_cmd(OP_STATUS, 12'h0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'hC3EB) begin
      errors++; $display("[TB] FAIL rb_status: got v=%b d=%h expected v=1 d=c3eb", resp_valid, resp_data);
    end
    send_cmd(OP_SET_RADDR, 12'd0);
    for (int c = 0; c < 16; c++) begin
      send_cmd(OP_READ, 12'(c));
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rb_early_c%0d: got %b expected 0", c, resp_valid);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== {4'(c), 12'd97}) begin
        errors++; $display("[TB] FAIL rb_chunk_c%0d: got v=%b d=%h expected v=1 d=%h", c, resp_valid, resp_data, {4'(c), 12'd97});
      end
    end
    send_cmd(OP_READ, 12'd0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h0062) begin
      errors++; $display("[TB] FAIL rb_r_advance: got v=%b d=%h expected v=1 d=0062", resp_valid, resp_data);
    end
  endtask

  task automatic test_back_to_back;
    host = {12'd3, OP_READ, 1'b1};
    @(negedge clk);
    host = {12'd0, OP_STATUS, 1'b1};
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_early: got %b expected 0", resp_valid);
    end
    @(negedge clk);
    host = '0;
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h3062) begin
      errors++; $display("[TB] FAIL b2b_read: got v=%b d=%h expected v=1 d=3062", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'hC3EB) begin
      errors++; $display("[TB] FAIL b2b_status: got v=%b d=%h expected v=1 d=c3eb", resp_valid, resp_data);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_end: got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_arm_ignored;
    send_cmd(OP_SET_TRIG, {4'd1, 8'h34});
    send_cmd(OP_SET_TRIG, {4'd2, 8'h12});
    send_cmd(OP_SET_TRIG, {4'd4, 8'hFF});
    trig0 = '0;
    send_cmd(OP_ARM, 12'd2);
    repeat (3) @(negedge clk);
    send_cmd(OP_ARM, 12'd6);
    checks++;
    if (armed_o !== 1'b1 || trig_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rearm_state: got a=%b t=%b expected a=1 t=0", armed_o, trig_o);
    end
    trig0[15:0] = 16'h1234;
    @(negedge clk);
    trig0 = '0;
    checks++;
    if (trig_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rearm_trig: got %b expected 1", trig_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rearm_done_early: got %b expected 0", done_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rearm_n_kept: got %b expected 1", done_o);
    end
  endtask

  task automatic test_abort;
    send_cmd(OP_SET_TRIG, {4'd3, 8'h00});
    send_cmd(OP_SET_TRIG, {4'd4, 8'h00});
    send_cmd(OP_ARM, 12'd100);
    @(negedge clk);
    checks++;
    if (trig_o !== 1'b1 || armed_o !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_in_post: got t=%b a=%b expected t=1 a=1", trig_o, armed_o);
    end
    send_cmd(OP_ABORT, 12'h0);
    checks++;
    if (control[19:17] !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_flags: got %b expected 000", control[19:17]);
    end
    send_cmd(OP_ARM, 12'd5);
    send_cmd(OP_ABORT, 12'h0);
    checks++;
    if (control[19:17] !== 3'b000) begin
      errors++; $display("[TB] FAIL abort_beats_trig: got %b expected 000", control[19:17]);
    end
  endtask

  task automatic test_async_reset;
    send_cmd(OP_ARM, 12'd100);
    @(negedge clk);
    checks++;
    if (trig_o !== 1'b1) begin
      errors++; $display("[TB] FAIL ar_in_post: got %b expected 1", trig_o);
    end
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if (control[35:16] !== 20'h0) begin
      errors++; $display("[TB] FAIL ar_immediate: got %h expected 00000", control[35:16]);
    end
    @(negedge clk); rst_b = 1'b1;
    @(negedge clk);
    send_cmd(OP_STATUS, 12'h0);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 16'h0000) begin
      errors++; $display("[TB] FAIL ar_status: got v=%b d=%h expected v=1 d=0000", resp_valid, resp_data);
    end
    trig0 = 256'h1;
    send_cmd(OP_ARM, 12'd0);
    @(negedge clk);
    checks++;
    if (trig_o !== 1'b1) begin
      errors++; $display("[TB] FAIL ar_cfg_cleared: got %b expected 1", trig_o);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    host  = '0;
    trig0 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_trigger_beef();
    test_zero_mask();
    test_readback();
    test_back_to_back();
    test_arm_ignored();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
